spi_burst_ram_slave: RTL and testbench

Parametrised SPI slave fronting an on-chip single-port RAM, successor to the fixed 8-bit command/address slave. Generalises address and data width and memory depth. Adds burst transfers: one frame carries any number of data words, and the address auto-increments between words. Sits between the external SPI master pins and the memory array; `clk` is the SPI serial clock.

---
 rtl/spi_ram_pkg.sv | 25 ++
 rtl/spi_ram_mem.sv | 38 +++
 rtl/spi_burst_ram_slave.sv | 165 ++++++++++++++++
 tb/tb_spi_burst_ram_slave.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_pkg
// Purpose  : Opcode and FSM state encodings shared by the SPI burst RAM slave
// Revision : 1.0 - initial parametrised burst version
// ============================================================================
package spi_ram_pkg;

  // Two-bit command opcode, first received bit is the MSB
  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_READ  = 2'b11;

  // Frame state encoding
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] CMD   = 3'd1;
  localparam logic [2:0] WADDR = 3'd2;
  localparam logic [2:0] WDATA = 3'd3;
  localparam logic [2:0] RADDR = 3'd4;
  localparam logic [2:0] RTURN = 3'd5;
  localparam logic [2:0] RDATA = 3'd6;

endpackage
`default_nettype wire

// File: rtl/spi_ram_mem.sv
`default_nettype none
// ============================================================================
// Module   : spi_ram_mem
// Purpose  : Single-port synchronous RAM with registered read. Addresses at or
//            beyond DEPTH are treated as holes: writes dropped, reads give 0.
// Revision : 1.0 - initial parametrised burst version
// ============================================================================
module spi_ram_mem #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem [0:DEPTH-1];
  logic              w_in_range;

  assign w_in_range = (32'(addr) < 32'(DEPTH));

  // Array write, suppressed for out-of-range addresses
  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem[addr] <= din;
    end
  end

  // Registered read port; holes read back as zero
  always_ff @(posedge clk) begin
    dout <= w_in_range ? mem[addr] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/spi_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : spi_burst_ram_slave
// Purpose  : SPI slave (clk = SCK) fronting a single-port RAM. Two-bit opcode
//            then either an address load or a burst of data words with
//            optional address auto-increment.
// Revision : 1.0 - initial parametrised burst version
// ============================================================================
module spi_burst_ram_slave
  import spi_ram_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 256,
  parameter int AUTO_INC = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ss_n,
  input  logic mosi,
  output logic miso
);

  localparam int c_MAX_W = (ADDR_W > DATA_W) ? ADDR_W : DATA_W;
  localparam int c_CNT_W = (c_MAX_W > 1) ? $clog2(c_MAX_W) : 1;
  localparam logic [c_CNT_W-1:0] c_ADDR_LAST = c_CNT_W'(ADDR_W - 1);
  localparam logic [c_CNT_W-1:0] c_DATA_LAST = c_CNT_W'(DATA_W - 1);
  localparam logic [ADDR_W-1:0]  c_WRAP_ADDR = ADDR_W'(DEPTH - 1);

  logic [2:0]         r_state;
  logic               r_op_msb;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_addr_done;
  logic [ADDR_W-1:0]  r_ashift;
  logic [DATA_W-1:0]  r_shift;
  logic [ADDR_W-1:0]  r_wr_addr;
  logic [ADDR_W-1:0]  r_rd_addr;

  logic               w_addr_last;
  logic               w_data_last;
  logic [ADDR_W-1:0]  w_addr_word;
  logic [DATA_W-1:0]  w_data_word;
  logic               w_mem_we;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_dout;

  // Address step: in-range addresses wrap at DEPTH-1, holes wrap at 2**ADDR_W
  function automatic logic [ADDR_W-1:0] f_next_addr(input logic [ADDR_W-1:0] a);
    if (AUTO_INC == 0) begin
      return a;
    end else if (a == c_WRAP_ADDR) begin
      return '0;
    end else begin
      return a + ADDR_W'(1);
    end
  endfunction

  assign w_addr_last = (r_cnt == c_ADDR_LAST);
  assign w_data_last = (r_cnt == c_DATA_LAST);
  // Shift-in views including the bit being sampled on this edge
  assign w_addr_word = ADDR_W'({r_ashift, mosi});
  assign w_data_word = DATA_W'({r_shift, mosi});

  // RAM reads rd_addr every cycle except during a write burst, so the word
  // needed at the next reload edge is already on dout
  assign w_mem_we   = !ss_n && (r_state == WDATA) && w_data_last;
  assign w_mem_addr = (r_state == WDATA) ? r_wr_addr : r_rd_addr;

  spi_ram_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk  (clk),
    .we   (w_mem_we),
    .addr (w_mem_addr),
    .din  (w_data_word),
    .dout (w_mem_dout)
  );

  // Frame FSM, shift registers and address counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op_msb    <= 1'b0;
      r_cnt       <= '0;
      r_addr_done <= 1'b0;
      r_ashift    <= '0;
      r_shift     <= '0;
      r_wr_addr   <= '0;
      r_rd_addr   <= '0;
    end else if (ss_n) begin
      // Frame boundary: partial words are simply dropped
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr_done <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_op_msb <= mosi;
          r_cnt    <= '0;
          r_state  <= CMD;
        end
        CMD: begin
          r_cnt       <= '0;
          r_addr_done <= 1'b0;
          case ({r_op_msb, mosi})
            OP_WADDR: r_state <= WADDR;
            OP_WRITE: r_state <= WDATA;
            OP_RADDR: r_state <= RADDR;
            default:  r_state <= RTURN;
          endcase
        end
        WADDR, RADDR: begin
          // Address bits beyond ADDR_W are ignored until deselect
          if (!r_addr_done) begin
            r_ashift <= w_addr_word;
            if (w_addr_last) begin
              if (r_state == WADDR) begin
                r_wr_addr <= w_addr_word;
              end else begin
                r_rd_addr <= w_addr_word;
              end
              r_addr_done <= 1'b1;
              r_cnt       <= '0;
            end else begin
              r_cnt <= r_cnt + c_CNT_W'(1);
            end
          end
        end
        WDATA: begin
          r_shift <= w_data_word;
          if (w_data_last) begin
            r_wr_addr <= f_next_addr(r_wr_addr);
            r_cnt     <= '0;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        RTURN: begin
          r_shift   <= w_mem_dout;
          r_rd_addr <= f_next_addr(r_rd_addr);
          r_cnt     <= '0;
          r_state   <= RDATA;
        end
        RDATA: begin
          // Reload on the edge that retires the LSB for a gapless burst
          if (w_data_last) begin
            r_shift   <= w_mem_dout;
            r_rd_addr <= f_next_addr(r_rd_addr);
            r_cnt     <= '0;
          end else begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_cnt   <= r_cnt + c_CNT_W'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign miso = (r_state == RDATA) & r_shift[DATA_W-1];

endmodule
`default_nettype wire

// File: tb/tb_spi_burst_ram_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_burst_ram_slave
// Purpose  : Scoreboard bench for the SPI burst RAM slave; a default instance
//            and a narrow-address, wide-data, no-increment instance.
// Revision : 1.0 - initial
// ============================================================================
module tb_spi_burst_ram_slave;

  typedef struct {
    int          cyc;
    int          kind;   // 0 miso A, 1 miso B, 2 mem A, 3 mem B
    int          addr;
    logic [15:0] exp;
    string       name;
  } chk_t;

  logic clk = 1'b0;
  logic rst_n;
  logic tb_ss;
  logic tb_mosi;
  logic sel;
  logic ss_a, ss_b, miso_a, miso_b;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  chk_t sb[$];

  assign ss_a = sel ? 1'b1 : tb_ss;
  assign ss_b = sel ? tb_ss : 1'b1;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  spi_burst_ram_slave u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ss_n  (ss_a),
    .mosi  (tb_mosi),
    .miso  (miso_a)
  );

  spi_burst_ram_slave #(
    .ADDR_W   (4),
    .DATA_W   (16),
    .DEPTH    (12),
    .AUTO_INC (0)
  ) u_dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .ss_n  (ss_b),
    .mosi  (tb_mosi),
    .miso  (miso_b)
  );

  // Monitor: pops every expectation due this cycle and compares at negedge
  always @(negedge clk) begin : p_mon
    chk_t        c;
    logic [15:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      c = sb.pop_front();
      case (c.kind)
        0:       act = {15'b0, miso_a};
        1:       act = {15'b0, miso_b};
        2:       act = {8'b0, u_dut.u_mem.mem[c.addr[7:0]]};
        default: act = u_dut2.u_mem.mem[c.addr[3:0]];
      endcase
      n_vec++;
      if (act !== c.exp) begin
        n_err++;
        $display("FAIL %s: got %h expected %h", c.name, act, c.exp);
      end
    end
  end

  task automatic push(input int kind, input int addr, input logic [15:0] exp, input string name);
    chk_t c;
    c.cyc  = cyc;
    c.kind = kind;
    c.addr = addr;
    c.exp  = exp;
    c.name = name;
    sb.push_back(c);
  endtask

  task automatic edge1(input logic s, input logic m);
    tb_ss   = s;
    tb_mosi = m;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) edge1(1'b0, v[i]);
  endtask

  task automatic gap();
    edge1(1'b1, 1'b0);
  endtask

  task automatic set_addr(input logic wr, input int aw, input logic [31:0] a);
    send(wr ? 32'd0 : 32'd2, 2);
    send(a, aw);
    gap();
  endtask

  task automatic write_words(input int dw, input int nw, input logic [15:0] w0,
                             input logic [15:0] w1, input logic [15:0] w2);
    logic [15:0] w [3];
    w[0] = w0; w[1] = w1; w[2] = w2;
    send(32'd1, 2);
    for (int n = 0; n < nw; n++) send({16'b0, w[n]}, dw);
    gap();
  endtask

  // READ frame: expects word stream bit j on miso after edge 3+j, then 0
  task automatic read_check(input int kind, input int dw, input int nw,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input string tag);
    logic [15:0] w [3];
    logic        b;
    w[0] = w0; w[1] = w1; w[2] = w2;
    send(32'd3, 2);
    for (int j = 0; j < nw * dw; j++) begin
      edge1(1'b0, 1'b0);
      b = w[j / dw][dw - 1 - (j % dw)];
      push(kind, 0, {15'b0, b}, $sformatf("%s bit%0d", tag, j));
    end
    gap();
    push(kind, 0, 16'h0, {tag, " idle"});
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
  endtask

  initial begin
    sel = 1'b0; rst_n = 1'b0; tb_ss = 1'b1; tb_mosi = 1'b0;
    repeat (3) edge1(1'b1, 1'b0);
    push(0, 0, 16'h0, "reset miso A");
    push(1, 0, 16'h0, "reset miso B");
    rst_n = 1'b1;
    edge1(1'b1, 1'b0);

    // Single write surrounded by known neighbours
    set_addr(1'b1, 8, 32'h0C);
    write_words(8, 3, 16'h11, 16'h22, 16'h33);
    set_addr(1'b1, 8, 32'h0D);
    write_words(8, 1, 16'h55, 16'h0, 16'h0);
    push(2, 12, 16'h11, "mem12");
    push(2, 13, 16'h55, "mem13");
    push(2, 14, 16'h33, "mem14");

    set_addr(1'b0, 8, 32'h0D);
    read_check(0, 8, 1, 16'h55, 16'h0, 16'h0, "rd55");

    // Burst write and read across the wrap point
    set_addr(1'b1, 8, 32'hFE);
    write_words(8, 3, 16'hA1, 16'hA2, 16'hA3);
    push(2, 8'hFE, 16'hA1, "memFE");
    push(2, 8'hFF, 16'hA2, "memFF");
    push(2, 8'h00, 16'hA3, "mem00");
    set_addr(1'b0, 8, 32'hFE);
    read_check(0, 8, 3, 16'hA1, 16'hA2, 16'hA3, "burst");

    // Aborted word leaves RAM and wr_addr alone
    set_addr(1'b1, 8, 32'h20);
    write_words(8, 1, 16'h5A, 16'h0, 16'h0);
    push(2, 8'h20, 16'h5A, "mem20 init");
    set_addr(1'b1, 8, 32'h20);
    send(32'd1, 2);
    send(32'h1F, 5);
    gap();
    push(2, 8'h20, 16'h5A, "mem20 partial");
    write_words(8, 1, 16'hC3, 16'h0, 16'h0);
    push(2, 8'h20, 16'hC3, "mem20 full");

    // Reset mid-read while miso would be driving 1 (A1 bit5)
    set_addr(1'b0, 8, 32'hFE);
    send(32'd3, 2);
    repeat (3) edge1(1'b0, 1'b0);
    rst_n = 1'b0;
    tb_ss = 1'b1;
    #1;
    push(0, 0, 16'h0, "rst miso");
    repeat (2) edge1(1'b1, 1'b0);
    rst_n = 1'b1;
    edge1(1'b1, 1'b0);
    read_check(0, 8, 1, 16'hA3, 16'h0, 16'h0, "post-rst");

    // Narrow instance: no auto-increment, out-of-range holes
    sel = 1'b1;
    edge1(1'b1, 1'b0);
    set_addr(1'b1, 4, 32'd3);
    write_words(16, 2, 16'h1234, 16'hBEEF, 16'h0);
    push(3, 3, 16'hBEEF, "noinc mem3");
    set_addr(1'b1, 4, 32'd13);
    write_words(16, 1, 16'h7777, 16'h0, 16'h0);
    push(3, 3, 16'hBEEF, "oob wr mem3");
    set_addr(1'b0, 4, 32'd13);
    read_check(1, 16, 1, 16'h0, 16'h0, 16'h0, "oob rd");
    set_addr(1'b0, 4, 32'd3);
    read_check(1, 16, 2, 16'hBEEF, 16'hBEEF, 16'h0, "noinc rd");

    repeat (2) edge1(1'b1, 1'b0);
    if (sb.size() != 0) begin
      $display("FAIL drain: got %0d pending expected 0", sb.size());
      n_err += sb.size();
    end
    summary();
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_err++;
    summary();
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
